// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg                                                             |
// | Shared pipeline-register types: EX control bundle and bubble value.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

    localparam int REG_IDX_W = 3;
    localparam int OPCODE_W  = 7;

    typedef struct packed {
        logic                 valid;
        logic                 load;
        logic                 wb_en;
        logic [OPCODE_W-1:0]  opcode;
        logic [REG_IDX_W-1:0] rsrc1;
        logic [REG_IDX_W-1:0] rsrc2;
        logic [REG_IDX_W-1:0] rdst;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

    // An invalid slot must never look like a load or a writer to the hazard logic.
    function automatic ex_ctrl_t make_ctrl(
        input logic                 valid,
        input logic                 load,
        input logic                 wb_en,
        input logic [OPCODE_W-1:0]  opcode,
        input logic [REG_IDX_W-1:0] rsrc1,
        input logic [REG_IDX_W-1:0] rsrc2,
        input logic [REG_IDX_W-1:0] rdst
    );
        ex_ctrl_t c;
        c.valid  = valid;
        c.load   = load & valid;
        c.wb_en  = wb_en & valid;
        c.opcode = opcode;
        c.rsrc1  = rsrc1;
        c.rsrc2  = rsrc2;
        c.rdst   = rdst;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_pipe_reg_if                                                    |
// | Decode-side inputs, hazard controls and EX-side outputs of ID/EX.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    import pipe_pkg::*;

    logic                 d_valid;
    logic [OPCODE_W-1:0]  d_opcode;
    logic [REG_IDX_W-1:0] d_rsrc1;
    logic [REG_IDX_W-1:0] d_rsrc2;
    logic [REG_IDX_W-1:0] d_rdst;
    logic [DATA_W-1:0]    d_rs1_val;
    logic [DATA_W-1:0]    d_rs2_val;
    logic [DATA_W-1:0]    d_imm;
    logic                 d_load;
    logic                 d_wb_en;
    logic                 stallD;
    logic                 flushE;
    logic                 mem_stall;

    logic                 ex_valid;
    logic                 ex_load;
    logic                 ex_wb_en;
    logic [OPCODE_W-1:0]  ex_opcode;
    logic [REG_IDX_W-1:0] ex_rsrc1;
    logic [REG_IDX_W-1:0] ex_rsrc2;
    logic [REG_IDX_W-1:0] ex_rdst;
    logic [DATA_W-1:0]    ex_rs1_val;
    logic [DATA_W-1:0]    ex_rs2_val;
    logic [DATA_W-1:0]    ex_imm;
    logic                 fd_hold;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;

    modport master (
        output d_valid, d_opcode, d_rsrc1, d_rsrc2, d_rdst,
               d_rs1_val, d_rs2_val, d_imm, d_load, d_wb_en,
               stallD, flushE, mem_stall,
        input  ex_valid, ex_load, ex_wb_en, ex_opcode, ex_rsrc1, ex_rsrc2,
               ex_rdst, ex_rs1_val, ex_rs2_val, ex_imm, fd_hold,
               stall_cnt, bubble_cnt
    );

    modport slave (
        input  d_valid, d_opcode, d_rsrc1, d_rsrc2, d_rdst,
               d_rs1_val, d_rs2_val, d_imm, d_load, d_wb_en,
               stallD, flushE, mem_stall,
        output ex_valid, ex_load, ex_wb_en, ex_opcode, ex_rsrc1, ex_rsrc2,
               ex_rdst, ex_rs1_val, ex_rs2_val, ex_imm, fd_hold,
               stall_cnt, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_reg_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Up-counter that sticks at all-ones; hold freezes it.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !hold && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_pipe_reg                                                       |
// | Decode-to-execute register with bubble injection, freeze and stats.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_pipe_reg_if.slave bus
);
    ex_ctrl_t          r_ctrl;
    logic [DATA_W-1:0] r_rs1_val;
    logic [DATA_W-1:0] r_rs2_val;
    logic [DATA_W-1:0] r_imm;
    logic              w_bubble;
    logic              w_stall_valid;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic [CNT_W-1:0]  w_bubble_cnt;

    // Flush and stall collapse into a single bubble on the same edge.
    assign w_bubble      = bus.flushE | bus.stallD;
    assign w_stall_valid = bus.stallD & bus.d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= EX_BUBBLE;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
        end else if (!bus.mem_stall) begin
            if (w_bubble) begin
                r_ctrl    <= EX_BUBBLE;
                r_rs1_val <= '0;
                r_rs2_val <= '0;
                r_imm     <= '0;
            end else begin
                r_ctrl    <= make_ctrl(bus.d_valid, bus.d_load, bus.d_wb_en,
                                       bus.d_opcode, bus.d_rsrc1, bus.d_rsrc2,
                                       bus.d_rdst);
                r_rs1_val <= bus.d_rs1_val;
                r_rs2_val <= bus.d_rs2_val;
                r_imm     <= bus.d_imm;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_valid),
        .hold  (bus.mem_stall),
        .count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble),
        .hold  (bus.mem_stall),
        .count (w_bubble_cnt)
    );

    assign bus.ex_valid   = r_ctrl.valid;
    assign bus.ex_load    = r_ctrl.load;
    assign bus.ex_wb_en   = r_ctrl.wb_en;
    assign bus.ex_opcode  = r_ctrl.opcode;
    assign bus.ex_rsrc1   = r_ctrl.rsrc1;
    assign bus.ex_rsrc2   = r_ctrl.rsrc2;
    assign bus.ex_rdst    = r_ctrl.rdst;
    assign bus.ex_rs1_val = r_rs1_val;
    assign bus.ex_rs2_val = r_rs2_val;
    assign bus.ex_imm     = r_imm;
    assign bus.fd_hold    = bus.stallD | bus.mem_stall;
    assign bus.stall_cnt  = w_stall_cnt;
    assign bus.bubble_cnt = w_bubble_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_ex_pipe_reg                                                    |
// | Directed vector table for ID/EX plus a counter saturation sequence.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

    localparam logic [6:0] OP_ADD = 7'h01;
    localparam logic [6:0] OP_SUB = 7'h02;
    localparam logic [6:0] OP_LDD = 7'b0100000;
    localparam int         NVEC   = 17;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [6:0]  op;
        logic [2:0]  rs1, rs2, rd;
        logic [15:0] v1, v2, imm;
        logic        load, wb, stall, flush, mstall;
    } in_t;

    typedef struct {
        logic        hold, valid, load, wb;
        logic [6:0]  op;
        logic [2:0]  rs1, rs2, rd;
        logic [15:0] v1, v2, imm;
        logic [15:0] sc, bc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst;
    logic rst_s;
    int   checks;
    int   errors;

    id_ex_pipe_reg_if #(.DATA_W(16), .CNT_W(16)) bus   ();
    id_ex_pipe_reg_if #(.DATA_W(16), .CNT_W(4))  bus_s ();

    id_ex_pipe_reg #(.DATA_W(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_ex_pipe_reg #(.DATA_W(16), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(
        input logic a_rst, input logic a_valid, input logic [6:0] a_op,
        input logic [2:0] a_rs1, input logic [2:0] a_rs2, input logic [2:0] a_rd,
        input logic [15:0] a_v1, input logic [15:0] a_v2, input logic [15:0] a_imm,
        input logic a_load, input logic a_wb, input logic a_stall,
        input logic a_flush, input logic a_mstall
    );
        in_t r;
        r.rst = a_rst; r.valid = a_valid; r.op = a_op;
        r.rs1 = a_rs1; r.rs2 = a_rs2; r.rd = a_rd;
        r.v1 = a_v1; r.v2 = a_v2; r.imm = a_imm;
        r.load = a_load; r.wb = a_wb; r.stall = a_stall;
        r.flush = a_flush; r.mstall = a_mstall;
        return r;
    endfunction

    function automatic exp_t mk_ex(
        input logic a_hold, input logic a_valid, input logic a_load, input logic a_wb,
        input logic [6:0] a_op, input logic [2:0] a_rs1, input logic [2:0] a_rs2,
        input logic [2:0] a_rd, input logic [15:0] a_v1, input logic [15:0] a_v2,
        input logic [15:0] a_imm, input logic [15:0] a_sc, input logic [15:0] a_bc
    );
        exp_t r;
        r.hold = a_hold; r.valid = a_valid; r.load = a_load; r.wb = a_wb;
        r.op = a_op; r.rs1 = a_rs1; r.rs2 = a_rs2; r.rd = a_rd;
        r.v1 = a_v1; r.v2 = a_v2; r.imm = a_imm; r.sc = a_sc; r.bc = a_bc;
        return r;
    endfunction

    function automatic exp_t mk_bubble(input logic a_hold, input logic [15:0] a_sc,
                                       input logic [15:0] a_bc);
        return mk_ex(a_hold, 1'b0, 1'b0, 1'b0, 7'h0, 3'd0, 3'd0, 3'd0,
                     16'h0, 16'h0, 16'h0, a_sc, a_bc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst            = v.rst;
        bus.d_valid    = v.valid;
        bus.d_opcode   = v.op;
        bus.d_rsrc1    = v.rs1;
        bus.d_rsrc2    = v.rs2;
        bus.d_rdst     = v.rd;
        bus.d_rs1_val  = v.v1;
        bus.d_rs2_val  = v.v2;
        bus.d_imm      = v.imm;
        bus.d_load     = v.load;
        bus.d_wb_en    = v.wb;
        bus.stallD     = v.stall;
        bus.flushE     = v.flush;
        bus.mem_stall  = v.mstall;
    endtask

    task automatic compare(input int k, input exp_t e);
        chk($sformatf("v%0d ex_valid", k),   32'(bus.ex_valid),   32'(e.valid));
        chk($sformatf("v%0d ex_load", k),    32'(bus.ex_load),    32'(e.load));
        chk($sformatf("v%0d ex_wb_en", k),   32'(bus.ex_wb_en),   32'(e.wb));
        chk($sformatf("v%0d ex_opcode", k),  32'(bus.ex_opcode),  32'(e.op));
        chk($sformatf("v%0d ex_rsrc1", k),   32'(bus.ex_rsrc1),   32'(e.rs1));
        chk($sformatf("v%0d ex_rsrc2", k),   32'(bus.ex_rsrc2),   32'(e.rs2));
        chk($sformatf("v%0d ex_rdst", k),    32'(bus.ex_rdst),    32'(e.rd));
        chk($sformatf("v%0d ex_rs1_val", k), 32'(bus.ex_rs1_val), 32'(e.v1));
        chk($sformatf("v%0d ex_rs2_val", k), 32'(bus.ex_rs2_val), 32'(e.v2));
        chk($sformatf("v%0d ex_imm", k),     32'(bus.ex_imm),     32'(e.imm));
        chk($sformatf("v%0d stall_cnt", k),  32'(bus.stall_cnt),  32'(e.sc));
        chk($sformatf("v%0d bubble_cnt", k), 32'(bus.bubble_cnt), 32'(e.bc));
    endtask

    vec_t vecs [NVEC];

    initial begin
        checks = 0;
        errors = 0;
        rst_s  = 1'b1;
        bus_s.d_valid = 1'b0; bus_s.d_opcode = 7'h0; bus_s.d_rsrc1 = 3'd0;
        bus_s.d_rsrc2 = 3'd0; bus_s.d_rdst = 3'd0; bus_s.d_rs1_val = 16'h0;
        bus_s.d_rs2_val = 16'h0; bus_s.d_imm = 16'h0; bus_s.d_load = 1'b0;
        bus_s.d_wb_en = 1'b0; bus_s.stallD = 1'b0; bus_s.flushE = 1'b0;
        bus_s.mem_stall = 1'b0;

        // Reset, including reset overriding freeze and stall.
        vecs[0]  = '{mk_in(1,1,OP_LDD,1,2,3,16'h5,16'h7,16'h9,1,1,0,0,0), mk_bubble(0,0,0)};
        vecs[1]  = '{mk_in(1,1,OP_LDD,1,2,3,16'h5,16'h7,16'h9,1,1,1,0,1), mk_bubble(1,0,0)};
        // Normal ADD, then a load followed by a dependent ADD.
        vecs[2]  = '{mk_in(0,1,OP_ADD,1,2,3,16'h0005,16'h0007,16'h0011,0,1,0,0,0),
                     mk_ex(0,1,0,1,OP_ADD,1,2,3,16'h0005,16'h0007,16'h0011,0,0)};
        vecs[3]  = '{mk_in(0,1,OP_LDD,2,0,4,16'h0100,16'h0000,16'h0008,1,1,0,0,0),
                     mk_ex(0,1,1,1,OP_LDD,2,0,4,16'h0100,16'h0000,16'h0008,0,0)};
        vecs[4]  = '{mk_in(0,1,OP_ADD,4,4,5,16'h1111,16'h2222,16'h0000,0,1,1,0,0), mk_bubble(1,1,1)};
        vecs[5]  = '{mk_in(0,1,OP_ADD,4,4,5,16'h1111,16'h2222,16'h0000,0,1,0,0,0),
                     mk_ex(0,1,0,1,OP_ADD,4,4,5,16'h1111,16'h2222,16'h0000,1,1)};
        // Flush with stall is one bubble; flush alone; stall of an invalid slot.
        vecs[6]  = '{mk_in(0,1,OP_SUB,1,1,6,16'h3333,16'h3333,16'h0003,0,1,1,1,0), mk_bubble(1,2,2)};
        vecs[7]  = '{mk_in(0,1,OP_SUB,1,1,6,16'h3333,16'h3333,16'h0003,0,1,0,1,0), mk_bubble(0,2,3)};
        vecs[8]  = '{mk_in(0,0,OP_SUB,1,1,6,16'h3333,16'h3333,16'h0003,0,1,1,0,0), mk_bubble(1,2,4)};
        // Invalid slot: fields load, but load/wb_en are gated off.
        vecs[9]  = '{mk_in(0,0,OP_LDD,3,1,7,16'hAAAA,16'h5555,16'h00FF,1,1,0,0,0),
                     mk_ex(0,0,0,0,OP_LDD,3,1,7,16'hAAAA,16'h5555,16'h00FF,2,4)};
        // Freeze: EX holds rdst=5/BEEF through flush+stall, counters frozen.
        vecs[10] = '{mk_in(0,1,OP_ADD,1,2,5,16'hBEEF,16'h0001,16'h0002,0,1,0,0,0),
                     mk_ex(0,1,0,1,OP_ADD,1,2,5,16'hBEEF,16'h0001,16'h0002,2,4)};
        for (int k = 11; k <= 13; k++)
            vecs[k] = '{mk_in(0,1,OP_SUB,6,7,6,16'h1234,16'h5678,16'h9ABC,1,1,1,1,1),
                        mk_ex(1,1,0,1,OP_ADD,1,2,5,16'hBEEF,16'h0001,16'h0002,2,4)};
        vecs[14] = '{mk_in(0,1,OP_SUB,6,7,6,16'h1234,16'h5678,16'h9ABC,1,1,0,0,1),
                     mk_ex(1,1,0,1,OP_ADD,1,2,5,16'hBEEF,16'h0001,16'h0002,2,4)};
        vecs[15] = '{mk_in(0,1,OP_SUB,6,7,6,16'h1234,16'h5678,16'h9ABC,1,1,0,0,0),
                     mk_ex(0,1,1,1,OP_SUB,6,7,6,16'h1234,16'h5678,16'h9ABC,2,4)};
        vecs[16] = '{mk_in(1,1,OP_SUB,6,7,6,16'h1234,16'h5678,16'h9ABC,1,1,0,0,0), mk_bubble(0,0,0)};

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].i);
            #1;
            chk($sformatf("v%0d fd_hold", k), 32'(bus.fd_hold), 32'(vecs[k].e.hold));
            @(posedge clk);
            #1;
            compare(k, vecs[k].e);
        end

        // Saturation on a 4-bit counter instance.
        @(posedge clk);
        #1;
        chk("sat reset stall_cnt", 32'(bus_s.stall_cnt), 32'h0);
        chk("sat reset bubble_cnt", 32'(bus_s.bubble_cnt), 32'h0);
        rst_s = 1'b0;
        bus_s.d_valid = 1'b1;
        bus_s.stallD  = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 14) chk("sat stall_cnt at 14", 32'(bus_s.stall_cnt), 32'hE);
            if (n == 15) chk("sat stall_cnt at 15", 32'(bus_s.stall_cnt), 32'hF);
        end
        chk("sat stall_cnt at 20", 32'(bus_s.stall_cnt), 32'hF);
        chk("sat bubble_cnt at 20", 32'(bus_s.bubble_cnt), 32'hF);
        chk("sat fd_hold", 32'(bus_s.fd_hold), 32'h1);
        chk("sat ex_valid", 32'(bus_s.ex_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
